// File: rtl/ps2_command_sender_pkg.sv
// ps2_command_sender_pkg: transmitter state encoding, default timing and frame builder
package ps2_command_sender_pkg;
  localparam int unsigned PS2_INHIBIT_CYCLES = 5000;
  localparam int unsigned PS2_START_TIMEOUT  = 750000;
  localparam int unsigned PS2_XFER_TIMEOUT   = 100000;
  localparam int unsigned PS2_CNT_W          = 20;
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_REQUEST,
    TX_SEND,
    TX_WAIT_RELEASE,
    TX_ERR_TO,
    TX_ERR_NA
  } tx_state_e;
  function automatic logic [8:0] frame_bits(input logic [7:0] b);
    return {~^b, b};
  endfunction
endpackage

// File: rtl/ps2_command_sender_line_sync.sv
// ps2_command_sender_line_sync: 2-flop synchronizers for PS2 clk/dat plus clock falling-edge detect
module ps2_command_sender_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_i,
  input  logic dat_i,
  output logic clk_o,
  output logic dat_o,
  output logic clk_fall_o
);
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;
  // Idle PS/2 lines sit high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk)
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_i};
      dat_sync_q <= {dat_sync_q[0], dat_i};
      clk_prev_q <= clk_sync_q[1];
    end
  assign clk_o      = clk_sync_q[1];
  assign dat_o      = dat_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];
endmodule

// File: rtl/ps2_command_sender.sv
// ps2_command_sender: host-to-device PS/2 command byte transmitter with ACK and timeout checks
module ps2_command_sender
  import ps2_command_sender_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int unsigned XFER_TIMEOUT   = PS2_XFER_TIMEOUT,
  parameter int unsigned CNT_W          = PS2_CNT_W
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] commandToSend,
  input  logic       sendCommand,
  input  logic       ps2ClkIn,
  input  logic       ps2DatIn,
  output logic       ps2ClkDriveLow,
  output logic       ps2DatDriveLow,
  output logic       busy,
  output logic       commandWasSent,
  output logic       errorCommunicationTimedOut,
  output logic       errorNoAck
);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_TO = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] XFER_TO  = CNT_W'(XFER_TIMEOUT);
  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       edge_q, edge_d;
  logic             clk_low_q, dat_low_q, dat_low_d;
  logic             done_q, done_d, to_q, to_d, na_q, na_d;
  logic             clk_sync, dat_sync, clk_fall;
  ps2_command_sender_line_sync u_sync (
    .clk        (CLOCK_50),
    .rst        (resetn),
    .clk_i      (ps2ClkIn),
    .dat_i      (ps2DatIn),
    .clk_o      (clk_sync),
    .dat_o      (dat_sync),
    .clk_fall_o (clk_fall)
  );
  always_comb begin
    state_d   = state_q;
    timer_d   = (&timer_q) ? timer_q : timer_q + CNT_W'(1);
    shift_d   = shift_q;
    edge_d    = edge_q;
    dat_low_d = dat_low_q;
    done_d    = 1'b0;
    to_d      = 1'b0;
    na_d      = 1'b0;
    case (state_q)
      TX_IDLE:
        if (sendCommand) begin
          state_d = TX_INHIBIT;
          shift_d = frame_bits(commandToSend);
          timer_d = '0;
          edge_d  = '0;
        end
      TX_INHIBIT:
        if (timer_q == INH_LAST) begin
          state_d   = TX_REQUEST;
          timer_d   = '0;
          dat_low_d = 1'b1;
        end
      TX_REQUEST:
        if (clk_fall) begin
          state_d   = TX_SEND;
          dat_low_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          edge_d    = 4'd1;
          timer_d   = '0;
        end else if (timer_q >= START_TO) state_d = TX_ERR_TO;
      // Falls 2..9 shift out data1..7 and parity, fall 10 is the stop bit, fall 11 samples ACK.
      TX_SEND:
        if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q == 4'd10) state_d = dat_sync ? TX_ERR_NA : TX_WAIT_RELEASE;
          else if (edge_q == 4'd9) dat_low_d = 1'b0;
          else begin
            dat_low_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else if (timer_q >= XFER_TO) state_d = TX_ERR_TO;
      TX_WAIT_RELEASE:
        if (clk_sync & dat_sync) begin
          state_d = TX_IDLE;
          done_d  = 1'b1;
        end else if (timer_q >= XFER_TO) state_d = TX_ERR_TO;
      TX_ERR_TO: begin
        state_d = TX_IDLE;
        to_d    = 1'b1;
      end
      TX_ERR_NA: begin
        state_d = TX_IDLE;
        na_d    = 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
    if (state_d inside {TX_IDLE, TX_INHIBIT, TX_WAIT_RELEASE, TX_ERR_TO, TX_ERR_NA}) dat_low_d = 1'b0;
  end
  always_ff @(posedge CLOCK_50)
    if (resetn) begin
      state_q   <= TX_IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      edge_q    <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      na_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      edge_q    <= edge_d;
      clk_low_q <= state_d == TX_INHIBIT;
      dat_low_q <= dat_low_d;
      done_q    <= done_d;
      to_q      <= to_d;
      na_q      <= na_d;
    end
  assign ps2ClkDriveLow             = clk_low_q;
  assign ps2DatDriveLow             = dat_low_q;
  assign busy                       = state_q != TX_IDLE;
  assign commandWasSent             = done_q;
  assign errorCommunicationTimedOut = to_q;
  assign errorNoAck                 = na_q;
endmodule

// File: tb/tb_ps2_command_sender.sv
// tb_ps2_command_sender: keyboard BFM driving table-driven frames plus timeout/reset/busy corner cases
module tb_ps2_command_sender;
  localparam int INH = 50;
  localparam int START_TO = 400;
  localparam int XFER_TO = 1500;
  localparam int H = 20;
  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    bit         par;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       kclk = 1'b1;
  logic       kdat = 1'b1;
  logic       clk_low, dat_low, busy, done, err_to, err_na;
  logic       pin_clk, pin_dat;
  logic [9:0] rx_bits;
  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_to = 0, n_na = 0, n_idle = 0, n_inh = 0, inh_run = 0, last_inh = 0;
  vec_t vecs[6];
  assign pin_clk = kclk & ~clk_low;
  assign pin_dat = kdat & ~dat_low;
  always #5 clk = ~clk;
  ps2_command_sender #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (START_TO),
    .XFER_TIMEOUT   (XFER_TO),
    .CNT_W          (12)
  ) dut (
    .CLOCK_50                   (clk),
    .resetn                     (rst),
    .commandToSend              (cmd),
    .sendCommand                (send),
    .ps2ClkIn                   (pin_clk),
    .ps2DatIn                   (pin_dat),
    .ps2ClkDriveLow             (clk_low),
    .ps2DatDriveLow             (dat_low),
    .busy                       (busy),
    .commandWasSent             (done),
    .errorCommunicationTimedOut (err_to),
    .errorNoAck                 (err_na)
  );
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) n_done <= n_done + 1;
    if (err_to) n_to <= n_to + 1;
    if (err_na) n_na <= n_na + 1;
    if (!busy) n_idle <= n_idle + 1;
    if (clk_low) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      last_inh <= inh_run;
      n_inh <= n_inh + 1;
      inh_run <= 0;
    end
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic issue(input logic [7:0] c);
    @(negedge clk);
    cmd = c;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INH + 100 && !ok; i++) begin
      @(negedge clk);
      if (dat_low && !clk_low) ok = 1'b1;
    end
  endtask
  task automatic dev_clock(input int first, input int last, input bit ack);
    for (int i = first; i <= last; i++) begin
      if (i == 11) kdat = ack ? 1'b0 : 1'b1;
      kclk = 1'b0;
      repeat (H) @(negedge clk);
      if (i <= 10) rx_bits[i-1] = pin_dat;
      kclk = 1'b1;
      if (i == 11) kdat = 1'b1;
      if (i < last) repeat (H) @(negedge clk);
    end
  endtask
  task automatic run_frame(input vec_t v);
    bit ok;
    int s_done, s_to, s_na, s_idle;
    s_done = n_done;
    s_to = n_to;
    s_na = n_na;
    issue(v.cmd);
    s_idle = n_idle;
    wait_req(ok);
    check("req_seen", int'(ok), 1);
    repeat (10) @(negedge clk);
    check("inhibit_len", last_inh, INH);
    dev_clock(1, 11, v.ack);
    check("data_byte", int'(rx_bits[7:0]), int'(v.cmd));
    check("parity", int'(rx_bits[8]), int'(v.par));
    check("stop_bit", int'(rx_bits[9]), 1);
    if (v.ack) check("busy_held", n_idle - s_idle, 0);
    repeat (20) @(negedge clk);
    check("done_pulses", n_done - s_done, int'(v.ack));
    check("noack_pulses", n_na - s_na, int'(!v.ack));
    check("timeout_pulses", n_to - s_to, 0);
    check("idle_busy", int'(busy), 0);
    check("idle_lines", int'({clk_low, dat_low}), 0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    int k, k0, s_done, s_to, s_na, s_inh;
    vecs[0] = '{8'hED, 1'b1, 1'b1};
    vecs[1] = '{8'hF4, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1};
    repeat (5) @(negedge clk);
    check("rst_clk_low", int'(clk_low), 0);
    check("rst_dat_low", int'(dat_low), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({done, err_to, err_na}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);
    s_done = n_done;
    s_to = n_to;
    issue(8'hED);
    wait_req(ok);
    check("start_req_seen", int'(ok), 1);
    k = 0;
    while (k < START_TO + 50 && !err_to) begin
      @(negedge clk);
      k++;
    end
    check("start_to_fired", int'(err_to), 1);
    check("start_to_window", int'(k >= START_TO && k <= START_TO + 3), 1);
    check("start_to_lines", int'({clk_low, dat_low}), 0);
    check("start_to_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    check("start_to_count", n_to - s_to, 1);
    check("start_to_no_done", n_done - s_done, 0);
    s_done = n_done;
    s_to = n_to;
    issue(8'hF4);
    wait_req(ok);
    repeat (10) @(negedge clk);
    k0 = cyc;
    dev_clock(1, 4, 1'b1);
    while (cyc - k0 < XFER_TO + 50 && !err_to) @(negedge clk);
    k = cyc - k0;
    check("xfer_to_fired", int'(err_to), 1);
    check("xfer_to_window", int'(k >= XFER_TO && k <= XFER_TO + 8), 1);
    check("xfer_to_lines", int'({clk_low, dat_low}), 0);
    repeat (5) @(negedge clk);
    check("xfer_to_count", n_to - s_to, 1);
    check("xfer_to_no_done", n_done - s_done, 0);
    issue(8'h00);
    wait_req(ok);
    repeat (10) @(negedge clk);
    dev_clock(1, 4, 1'b1);
    check("pre_rst_dat_low", int'(dat_low), 1);
    s_done = n_done;
    s_to = n_to;
    s_na = n_na;
    rst = 1'b1;
    @(negedge clk);
    check("abort_lines", int'({clk_low, dat_low}), 0);
    check("abort_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_pulses", (n_done - s_done) + (n_to - s_to) + (n_na - s_na), 0);
    s_done = n_done;
    s_inh = n_inh;
    issue(8'hF4);
    wait_req(ok);
    repeat (10) @(negedge clk);
    dev_clock(1, 5, 1'b1);
    issue(8'h00);
    repeat (H) @(negedge clk);
    dev_clock(6, 11, 1'b1);
    check("ignore_byte", int'(rx_bits[7:0]), 8'hF4);
    check("ignore_parity", int'(rx_bits[8]), 0);
    repeat (200) @(negedge clk);
    check("ignore_done", n_done - s_done, 1);
    check("ignore_frames", n_inh - s_inh, 1);
    check("ignore_busy", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
